pirdsp_simd_dot_acc: RTL and testbench

//  Pipelined, parametrised SIMD dot-product engine for the PIR-DSP datapath.

---
 rtl/pirdsp_simd_dot_acc.sv | 157 +++++++++++++++
 tb/tb_pirdsp_simd_dot_acc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pirdsp_simd_dot_acc.sv
// SIMD dot-product engine: lane-wise multiply, per-group sum, per-group accumulation across beats.
// Latency: an accepted LAST beat gives out_valid 3 cycles later (S1 operands, S2 products, S3 accumulators).
// Backpressure: a held result (out_valid && !out_ready) freezes every stage and drops in_ready.
module pirdsp_simd_dot_acc #(
  parameter int LANE_W = 9,
  parameter int LANES  = 6,
  parameter int GROUPS = 2,
  parameter int ACC_W  = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_a,
  input  logic [LANES*LANE_W-1:0] in_b,
  input  logic                    in_signed,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [GROUPS*ACC_W-1:0] out_data,
  output logic [GROUPS-1:0]       out_ovf
);
  localparam int LPG = LANES / GROUPS;
  localparam int PW  = 2 * LANE_W;

  generate
    if (LANES % GROUPS != 0) begin : g_bad_lanes
      $error("LANES must be a multiple of GROUPS");
    end
    if (ACC_W < PW + $clog2(LPG)) begin : g_bad_acc
      $error("ACC_W too narrow for a full group sum");
    end
  endgenerate

  logic                    stall;
  logic                    s1_vld, s1_signed, s1_last;
  logic [LANES*LANE_W-1:0] s1_a, s1_b;
  logic                    s2_vld, s2_signed, s2_last;
  logic [PW-1:0]           s2_prod  [LANES];
  logic [PW-1:0]           ext_a    [LANES];
  logic [PW-1:0]           ext_b    [LANES];
  logic [PW-1:0]           prod_nxt [LANES];
  logic                    s3_vld, s3_last, fresh;
  logic [ACC_W-1:0]        acc      [GROUPS];
  logic [ACC_W-1:0]        gsum     [GROUPS];
  logic [ACC_W-1:0]        acc_nxt  [GROUPS];
  logic [ACC_W:0]          acc_wide [GROUPS];
  logic [GROUPS-1:0]       ovf, ovf_step;

  // Only a presented-but-unaccepted result blocks the pipe
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = s3_vld && s3_last;
  assign out_ovf   = ovf;

  // Extend each lane to 2*LANE_W per the beat's signedness; low PW bits of the product are exact
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      ext_a[i]    = {{LANE_W{s1_signed & s1_a[i*LANE_W+LANE_W-1]}}, s1_a[i*LANE_W +: LANE_W]};
      ext_b[i]    = {{LANE_W{s1_signed & s1_b[i*LANE_W+LANE_W-1]}}, s1_b[i*LANE_W +: LANE_W]};
      prod_nxt[i] = ext_a[i] * ext_b[i];
    end
  end

  // Group sums in accumulator width; cannot overflow given the ACC_W elaboration check
  always_comb begin
    for (int g = 0; g < GROUPS; g++) begin
      gsum[g] = '0;
      for (int l = 0; l < LPG; l++) begin
        if (s2_signed) gsum[g] = gsum[g] + ACC_W'($signed(s2_prod[g*LPG+l]));
        else           gsum[g] = gsum[g] + ACC_W'(s2_prod[g*LPG+l]);
      end
    end
  end

  // Accumulate with carry-out for unsigned beats and sign-based overflow for signed beats
  always_comb begin
    ovf_step = '0;
    for (int g = 0; g < GROUPS; g++) begin
      acc_wide[g] = {1'b0, acc[g]} + {1'b0, gsum[g]};
      acc_nxt[g]  = acc_wide[g][ACC_W-1:0];
      if (s2_signed)
        ovf_step[g] = (acc[g][ACC_W-1] == gsum[g][ACC_W-1]) &&
                      (acc_nxt[g][ACC_W-1] != acc[g][ACC_W-1]);
      else
        ovf_step[g] = acc_wide[g][ACC_W];
    end
  end

  // Result bus mirrors the accumulators, so it stays put while stalled
  always_comb begin
    out_data = '0;
    for (int g = 0; g < GROUPS; g++) out_data[g*ACC_W +: ACC_W] = acc[g];
  end

  // S1: capture operands and per-beat flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_signed <= 1'b0;
      s1_last   <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
    end else if (!stall) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_signed <= in_signed;
        s1_last   <= in_last;
        s1_a      <= in_a;
        s1_b      <= in_b;
      end
    end
  end

  // S2: register lane products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld    <= 1'b0;
      s2_signed <= 1'b0;
      s2_last   <= 1'b0;
      for (int i = 0; i < LANES; i++) s2_prod[i] <= '0;
    end else if (!stall) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_signed <= s1_signed;
        s2_last   <= s1_last;
        for (int i = 0; i < LANES; i++) s2_prod[i] <= prod_nxt[i];
      end
    end
  end

  // S3: accumulators; the beat after a LAST starts a fresh run and clears overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_vld  <= 1'b0;
      s3_last <= 1'b0;
      fresh   <= 1'b1;
      ovf     <= '0;
      for (int g = 0; g < GROUPS; g++) acc[g] <= '0;
    end else if (!stall) begin
      s3_vld <= s2_vld;
      if (s2_vld) begin
        s3_last <= s2_last;
        fresh   <= s2_last;
        for (int g = 0; g < GROUPS; g++) begin
          if (fresh) begin
            acc[g] <= gsum[g];
            ovf[g] <= 1'b0;
          end else begin
            acc[g] <= acc_nxt[g];
            ovf[g] <= ovf[g] | ovf_step[g];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pirdsp_simd_dot_acc.sv
// Bench for pirdsp_simd_dot_acc: directed spec scenarios plus randomized traffic.
// Reference model works on whole integers per beat and queues expected results per run.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_pirdsp_simd_dot_acc;
  localparam int LW  = 9;
  localparam int NL  = 6;
  localparam int NG  = 2;
  localparam int AW  = 24;
  localparam int LPG = NL / NG;
  localparam longint SMAX = (longint'(1) << (AW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (AW - 1));
  localparam longint UMOD = longint'(1) << AW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_signed = 1'b0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b1;
  logic [NL*LW-1:0] in_a = '0;
  logic [NL*LW-1:0] in_b = '0;
  logic             in_ready, out_valid;
  logic [NG*AW-1:0] out_data;
  logic [NG-1:0]    out_ovf;

  pirdsp_simd_dot_acc dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NG*AW-1:0] d;
    logic [NG-1:0]    o;
  } res_t;

  res_t          expq[$];
  int            checks = 0;
  int            passes = 0;
  int            fails = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  int            res_cyc = 0;
  int            n_results = 0;
  bit            chk_rdy = 1'b0;
  bit            toggle = 1'b0;
  bit            rnd_rdy = 1'b0;
  logic [NG*AW-1:0] last_d = '0;
  logic [NG-1:0]    last_o = '0;
  logic [AW-1:0] m_acc [NG];
  logic [NG-1:0] m_ovf = '0;
  bit            m_fresh = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint lane_val(input logic [LW-1:0] v, input bit sgn);
    if (sgn) return longint'($signed(v));
    return longint'(v);
  endfunction

  // Reference: exact integer dot products, accumulated with wrap and range-based overflow
  task automatic model_accept(input logic [NL*LW-1:0] a, input logic [NL*LW-1:0] b,
                              input bit sgn, input bit last);
    longint s, t;
    res_t   r;
    for (int g = 0; g < NG; g++) begin
      s = 0;
      for (int l = 0; l < LPG; l++)
        s += lane_val(a[(g*LPG+l)*LW +: LW], sgn) * lane_val(b[(g*LPG+l)*LW +: LW], sgn);
      if (m_fresh) begin
        m_acc[g] = s[AW-1:0];
        m_ovf[g] = 1'b0;
      end else begin
        if (sgn) begin
          t = longint'($signed(m_acc[g])) + s;
          if (t > SMAX || t < SMIN) m_ovf[g] = 1'b1;
        end else begin
          t = longint'(m_acc[g]) + s;
          if (t >= UMOD) m_ovf[g] = 1'b1;
        end
        m_acc[g] = t[AW-1:0];
      end
    end
    m_fresh = last;
    if (last) begin
      for (int g = 0; g < NG; g++) r.d[g*AW +: AW] = m_acc[g];
      r.o = m_ovf;
      expq.push_back(r);
    end
  endtask

  // One clock: sample at falling edge, commit at rising edge, update model and out_ready
  task automatic step(output bit accepted);
    res_t e;
    @(negedge clk);
    accepted = (in_valid && in_ready);
    if (chk_rdy) chk("in_ready_vs_stall", 64'(in_ready), 64'(!(out_valid && !out_ready)));
    if (out_valid && out_ready) begin
      chk("result_expected", 64'(expq.size() > 0), 64'(1));
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("out_data", 64'(out_data), 64'(e.d));
        chk("out_ovf", 64'(out_ovf), 64'(e.o));
      end
      last_d = out_data;
      last_o = out_ovf;
      res_cyc = cyc;
      n_results++;
    end
    @(posedge clk);
    #1;
    if (accepted) begin
      acc_cyc = cyc;
      model_accept(in_a, in_b, in_signed, in_last);
    end
    cyc++;
    if (toggle) out_ready = ~out_ready;
    else if (rnd_rdy) out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send(input logic [NL*LW-1:0] a, input logic [NL*LW-1:0] b,
                      input bit sgn, input bit last);
    bit done = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = sgn; in_last = last;
    for (int k = 0; k < 50 && !done; k++) step(done);
    chk("send_accepted", 64'(done), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit d;
    for (int k = 0; k < 80 && expq.size() != 0; k++) step(d);
    for (int k = 0; k < 3; k++) step(d);
    chk("drain_empty", 64'(expq.size()), 64'(0));
  endtask

  initial begin
    int n0;
    logic [63:0] r;
    logic [NL*LW-1:0] ra, rb;
    bit sgn, lst, d;
    for (int g = 0; g < NG; g++) m_acc[g] = '0;

    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_ovf", 64'(out_ovf), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(d);

    // 1: signed single beat, latency 3
    send({NL{9'h1FF}}, {NL{9'h002}}, 1'b1, 1'b1);
    drain();
    chk("t1_latency", 64'(res_cyc - acc_cyc), 64'(3));
    chk("t1_data", 64'(last_d), 64'({24'hFFFFFA, 24'hFFFFFA}));
    chk("t1_ovf", 64'(last_o), 64'(0));

    // 2: unsigned single beat
    send({NL{9'h1FF}}, {NL{9'h002}}, 1'b0, 1'b1);
    drain();
    chk("t2_data", 64'(last_d), 64'({24'h000BFA, 24'h000BFA}));

    // 3: four-beat accumulation, single result
    n0 = n_results;
    for (int k = 0; k < 4; k++) send({NL{9'h003}}, {NL{9'h003}}, 1'b1, k == 3);
    drain();
    chk("t3_count", 64'(n_results - n0), 64'(1));
    chk("t3_data", 64'(last_d), 64'({24'h00006C, 24'h00006C}));

    // 4: overflow over 43 beats, then a fresh run clears it
    for (int k = 0; k < 43; k++) send({NL{9'h100}}, {NL{9'h100}}, 1'b1, k == 42);
    drain();
    chk("t4_data", 64'(last_d), 64'({24'h810000, 24'h810000}));
    chk("t4_ovf", 64'(last_o), 64'(2'b11));
    send({NL{9'h000}}, {NL{9'h000}}, 1'b1, 1'b1);
    drain();
    chk("t4_fresh_data", 64'(last_d), 64'(0));
    chk("t4_fresh_ovf", 64'(last_o), 64'(0));

    // 5: backpressure with out_ready toggling every cycle
    n0 = n_results;
    toggle = 1'b1;
    chk_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      r = {$urandom(), $urandom()}; ra = r[NL*LW-1:0];
      r = {$urandom(), $urandom()}; rb = r[NL*LW-1:0];
      send(ra, rb, ($urandom_range(0, 1) == 1), 1'b1);
    end
    drain();
    toggle = 1'b0;
    chk_rdy = 1'b0;
    out_ready = 1'b1;
    chk("t5_count", 64'(n_results - n0), 64'(10));

    // Randomized runs: mixed signedness, random gaps and random out_ready
    rnd_rdy = 1'b1;
    for (int k = 0; k < 150; k++) begin
      r = {$urandom(), $urandom()}; ra = r[NL*LW-1:0];
      r = {$urandom(), $urandom()}; rb = r[NL*LW-1:0];
      sgn = ($urandom_range(0, 1) == 1);
      lst = ($urandom_range(0, 3) == 0) || (k == 149);
      send(ra, rb, sgn, lst);
      if ($urandom_range(0, 3) == 0) step(d);
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    // 6: reset mid-run discards partial sums
    send({NL{9'h005}}, {NL{9'h007}}, 1'b1, 1'b0);
    send({NL{9'h005}}, {NL{9'h007}}, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'(0));
    chk("t6_rst_out_data", 64'(out_data), 64'(0));
    chk("t6_rst_out_ovf", 64'(out_ovf), 64'(0));
    chk("t6_rst_in_ready", 64'(in_ready), 64'(1));
    m_fresh = 1'b1;
    m_ovf = '0;
    for (int g = 0; g < NG; g++) m_acc[g] = '0;
    expq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send({NL{9'h001}}, {NL{9'h001}}, 1'b1, 1'b1);
    drain();
    chk("t6_data", 64'(last_d), 64'({24'h000003, 24'h000003}));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
